// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the sine-ROM frame sequencer.
package wave_seq_pkg;
  localparam int FRAME_LEN = 64;
  localparam int ADDR_W    = 6;
  localparam int QTR_OFS   = 16;
  localparam int SAMPLE_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/wave_phase_acc.sv
// Phase/sample-index counters with stride addition and quadrature address offset.
// WAVE_SEQ_IQ_EN adds the cosine (quarter-period ahead) address output.
module wave_phase_acc
  import wave_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ld,
  input  logic [ADDR_W-1:0] step,
  output logic [ADDR_W-1:0] phase,
  output logic [ADDR_W-1:0] idx,
`ifdef WAVE_SEQ_IQ_EN
  output logic [ADDR_W-1:0] addr_quad,
`endif
  output logic              last
);
  logic [ADDR_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] step_q, step_d;

  assign last  = (idx_q == ADDR_W'(FRAME_LEN - 1));
  assign phase = phase_q;
  assign idx   = idx_q;
`ifdef WAVE_SEQ_IQ_EN
  assign addr_quad = phase_q + ADDR_W'(QTR_OFS);
`endif

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    step_d  = step_q;
    if (clear) begin
      phase_d = '0;
      idx_d   = '0;
      step_d  = step;
    end else if (ld) begin
      idx_d   = idx_q + 1'b1;
      // Rewind at the frame end so every frame restarts at address 0.
      phase_d = last ? '0 : phase_q + step_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      idx_q   <= '0;
      step_q  <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
    end
  end
endmodule

// File: rtl/wave_frame_seq.sv
// Sine-ROM stimulus sequencer streaming framed 64-sample blocks to the FFT input.
// Define WAVE_SEQ_IQ_EN for the quadrature ROM port and a complex (cos on DO_IM) tone.
module wave_frame_seq
  import wave_seq_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int NF_W      = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                STOP,
  input  logic [ADDR_W-1:0]   STEP,
  input  logic [NF_W-1:0]     NFRAMES,
  output logic [ADDR_W-1:0]   ROM_ADDR,
  input  logic [SAMPLE_W-1:0] ROM_DATA,
`ifdef WAVE_SEQ_IQ_EN
  output logic [ADDR_W-1:0]   ROM_ADDR_Q,
  input  logic [SAMPLE_W-1:0] ROM_DATA_Q,
`endif
  output logic [SAMPLE_W-1:0] DO_RE,
  output logic [SAMPLE_W-1:0] DO_IM,
  output logic                DO_VALID,
  input  logic                DI_READY,
  output logic                DO_SOF,
  output logic                DO_EOF,
  output logic                BUSY,
  output logic                DONE
);
  state_e              state_q, state_d;
  logic [NF_W-1:0]     fcnt_q, fcnt_d, fcnt_inc;
  logic [NF_W-1:0]     nframes_q, nframes_d;
  logic                stop_q, stop_d;
  logic [SAMPLE_W-1:0] re_q, re_d;
  logic                valid_q, valid_d;
  logic                sof_q, sof_d;
  logic                eof_q, eof_d;
  logic                done_q, done_d;
  logic                start_acc, ld, last, stop_pend, last_frame;
  logic [ADDR_W-1:0]   phase, idx;

  assign start_acc  = (state_q == ST_IDLE) && START;
  // Load a new sample whenever the output register is empty or being drained.
  assign ld         = (state_q == ST_RUN) && (!valid_q || DI_READY);
  assign stop_pend  = stop_q || STOP;
  assign fcnt_inc   = fcnt_q + 1'b1;
  assign last_frame = ((nframes_q != '0) && (fcnt_inc == nframes_q)) || stop_pend;

  wave_phase_acc u_phase_acc (
    .clk       (CLK),
    .rst       (RST),
    .clear     (start_acc),
    .ld        (ld),
    .step      (STEP),
    .phase     (phase),
    .idx       (idx),
`ifdef WAVE_SEQ_IQ_EN
    .addr_quad (ROM_ADDR_Q),
`endif
    .last      (last)
  );

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    nframes_d = nframes_q;
    re_d      = re_q;
    valid_d   = valid_q;
    sof_d     = sof_q;
    eof_d     = eof_q;
    done_d    = 1'b0;
    stop_d    = (state_q == ST_IDLE) ? 1'b0 : stop_pend;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_RUN;
          fcnt_d    = '0;
          nframes_d = NFRAMES;
        end
      end
      ST_RUN: begin
        if (ld && last) begin
          fcnt_d = fcnt_inc;
          if (last_frame) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (valid_q && DI_READY) begin
          state_d = ST_IDLE;
          done_d  = eof_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ld) begin
      re_d    = ROM_DATA;
      sof_d   = (idx == '0);
      eof_d   = last;
      valid_d = 1'b1;
    end else if (DI_READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      fcnt_q    <= '0;
      nframes_q <= '0;
      stop_q    <= 1'b0;
      re_q      <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      nframes_q <= nframes_d;
      stop_q    <= stop_d;
      re_q      <= re_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      done_q    <= done_d;
    end
  end

`ifdef WAVE_SEQ_IQ_EN
  logic [SAMPLE_W-1:0] im_q, im_d;

  always_comb begin
    im_d = ld ? ROM_DATA_Q : im_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) im_q <= '0;
    else     im_q <= im_d;
  end

  assign DO_IM = im_q;
`else
  assign DO_IM = '0;
`endif

  assign ROM_ADDR = phase;
  assign DO_RE    = re_q;
  assign DO_VALID = valid_q;
  assign DO_SOF   = sof_q;
  assign DO_EOF   = eof_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = done_q;
endmodule
